// File: rtl/mio_emesh_merge.sv
// Two-port emesh merge: one-entry buffer per input, round-robin arbiter, registered output.
// Define MIO_EMESH_MERGE_FIXED_PRIO_EN to replace round-robin with fixed priority to port B.
module mio_emesh_merge #(
  parameter int PW = 104
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          a_access_in,
  input  logic [PW-1:0] a_packet_in,
  output logic          a_wait_out,
  input  logic          b_access_in,
  input  logic [PW-1:0] b_packet_in,
  output logic          b_wait_out,
  output logic          access_out,
  output logic [PW-1:0] packet_out,
  input  logic          wait_in
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  logic          buf_valid_a;
  logic          buf_valid_b;
  logic [PW-1:0] buf_packet_a;
  logic [PW-1:0] buf_packet_b;
  logic          out_valid;
  logic [PW-1:0] out_packet;

  logic          out_ready;
  logic          load_a;
  logic          load_b;
  logic          any_valid;
  logic          grant;
  logic          grant_a;
  logic          grant_b;
  port_e         winner;
  logic [PW-1:0] win_packet;

  assign load_a    = a_access_in & ~buf_valid_a;
  assign load_b    = b_access_in & ~buf_valid_b;
  assign out_ready = ~out_valid | ~wait_in;
  assign any_valid = buf_valid_a | buf_valid_b;
  assign grant     = out_ready & any_valid;

`ifdef MIO_EMESH_MERGE_FIXED_PRIO_EN
  // Regfile responses always go first; port A waits while B keeps arriving.
  always_comb begin
    winner = PORT_A;
    if (buf_valid_b) begin
      winner = PORT_B;
    end
  end
`else
  port_e last_grant;

  always_comb begin
    winner = PORT_A;
    if (buf_valid_a && buf_valid_b) begin
      winner = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (buf_valid_b) begin
      winner = PORT_B;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      last_grant <= PORT_B;
    end else if (grant) begin
      last_grant <= winner;
    end
  end
`endif

  // winner is A only when buffer A is valid or nothing is, so grant implies a full buffer.
  assign grant_a    = grant & (winner == PORT_A);
  assign grant_b    = grant & (winner == PORT_B);
  assign win_packet = (winner == PORT_B) ? buf_packet_b : buf_packet_a;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      buf_valid_a  <= 1'b0;
      buf_packet_a <= '0;
    end else if (grant_a) begin
      buf_valid_a  <= 1'b0;
    end else if (load_a) begin
      buf_valid_a  <= 1'b1;
      buf_packet_a <= a_packet_in;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      buf_valid_b  <= 1'b0;
      buf_packet_b <= '0;
    end else if (grant_b) begin
      buf_valid_b  <= 1'b0;
    end else if (load_b) begin
      buf_valid_b  <= 1'b1;
      buf_packet_b <= b_packet_in;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid  <= 1'b0;
      out_packet <= '0;
    end else if (out_ready) begin
      out_valid <= any_valid;
      if (any_valid) begin
        out_packet <= win_packet;
      end
    end
  end

  assign a_wait_out = buf_valid_a;
  assign b_wait_out = buf_valid_b;
  assign access_out = out_valid;
  assign packet_out = out_packet;

endmodule

// File: tb/tb_mio_emesh_merge.sv
// Self-checking bench for mio_emesh_merge: transaction-level queue model plus directed
// literal checks (single beat, contention, backpressure, output hold, reset, idle, random).
module tb_mio_emesh_merge;

  localparam int PW = 104;
  typedef logic [PW-1:0] pkt_t;

`ifdef MIO_EMESH_MERGE_FIXED_PRIO_EN
  localparam bit RR = 1'b0;
`else
  localparam bit RR = 1'b1;
`endif

  logic clk = 1'b0;
  logic nreset;
  logic a_access_in, b_access_in;
  pkt_t a_packet_in, b_packet_in;
  logic a_wait_out, b_wait_out;
  logic access_out;
  pkt_t packet_out;
  logic wait_in;

  mio_emesh_merge #(.PW(PW)) dut (
    .clk(clk), .nreset(nreset),
    .a_access_in(a_access_in), .a_packet_in(a_packet_in), .a_wait_out(a_wait_out),
    .b_access_in(b_access_in), .b_packet_in(b_packet_in), .b_wait_out(b_wait_out),
    .access_out(access_out), .packet_out(packet_out), .wait_in(wait_in)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input pkt_t act, input pkt_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [7:0] tag, input logic [7:0] lo);
    return {tag, 88'h0, lo};
  endfunction

  // Source queues, scoreboards and flags shared by the processes below
  pkt_t src_a[$], src_b[$];
  pkt_t pushed_a[$], pushed_b[$];
  pkt_t got_a[$], got_b[$], got_all[$];
  int   got_cyc[$];
  bit   flush = 1'b0;
  bit   gap_en = 1'b0;
  int   cyc = 0;

  // Reference model: each port holds at most one beat; the output slot takes the
  // oldest pending beat by the arbitration rule whenever it is empty or draining.
  pkt_t m_qa[$], m_qb[$];
  bit   m_ov = 1'b0;
  pkt_t m_pkt = '0;
  bit   m_pref_a = 1'b1;
  int   m_resets = 0;

  initial begin
    bit la, lb;
    forever begin
      @(posedge clk or negedge nreset);
      if (!nreset) begin
        m_qa.delete(); m_qb.delete();
        m_ov = 1'b0; m_pkt = '0; m_pref_a = 1'b1;
        m_resets++;
      end else begin
        la = a_access_in && (m_qa.size() == 0);
        lb = b_access_in && (m_qb.size() == 0);
        if (!m_ov || !wait_in) begin
          if (m_qa.size() != 0 && (m_qb.size() == 0 || (RR && m_pref_a))) begin
            m_pkt = m_qa.pop_front(); m_ov = 1'b1; m_pref_a = 1'b0;
          end else if (m_qb.size() != 0) begin
            m_pkt = m_qb.pop_front(); m_ov = 1'b1; m_pref_a = 1'b1;
          end else begin
            m_ov = 1'b0;
          end
        end
        if (la) m_qa.push_back(a_packet_in);
        if (lb) m_qb.push_back(b_packet_in);
      end
    end
  end

  // Compare process: every cycle against the model, plus the output-hold rule and collection
  initial begin
    pkt_t prev_pkt = '0;
    bit   prev_stall = 1'b0;
    int   prev_resets = 0;
    forever begin
      @(negedge clk);
      cyc++;
      check("access_out", access_out, m_ov);
      check("packet_out", packet_out, m_pkt);
      check("a_wait_out", a_wait_out, m_qa.size() != 0);
      check("b_wait_out", b_wait_out, m_qb.size() != 0);
      if (packet_out !== prev_pkt && prev_resets == m_resets)
        check("hold_changed_while_stalled", prev_stall, 0);
      prev_pkt = packet_out;
      prev_stall = access_out && wait_in;
      prev_resets = m_resets;
      if (nreset && access_out && !wait_in) begin
        if (packet_out[PW-1 -: 8] == 8'hBB) got_b.push_back(packet_out);
        else got_a.push_back(packet_out);
        got_all.push_back(packet_out);
        got_cyc.push_back(cyc);
      end
    end
  end

  // Source drivers: hold access/packet until the beat transfers
  initial begin
    bit wa, wb, ta, tb;
    a_access_in = 1'b0; b_access_in = 1'b0;
    a_packet_in = '0;   b_packet_in = '0;
    forever begin
      @(negedge clk);
      wa = a_wait_out; wb = b_wait_out;
      @(posedge clk);
      ta = nreset && a_access_in && !wa;
      tb = nreset && b_access_in && !wb;
      if (ta) void'(src_a.pop_front());
      if (tb) void'(src_b.pop_front());
      #1;
      if (flush) begin
        src_a.delete(); src_b.delete();
        a_access_in = 1'b0; b_access_in = 1'b0;
      end else begin
        if (!a_access_in || ta) begin
          if (src_a.size() != 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
            a_access_in = 1'b1; a_packet_in = src_a[0];
          end else a_access_in = 1'b0;
        end
        if (!b_access_in || tb) begin
          if (src_b.size() != 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
            b_access_in = 1'b1; b_packet_in = src_b[0];
          end else b_access_in = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_sb();
    pushed_a.delete(); pushed_b.delete();
    got_a.delete(); got_b.delete(); got_all.delete(); got_cyc.delete();
  endtask

  task automatic push_a(input pkt_t p);
    src_a.push_back(p); pushed_a.push_back(p);
  endtask

  task automatic push_b(input pkt_t p);
    src_b.push_back(p); pushed_b.push_back(p);
  endtask

  task automatic cmp_q(input string name, input pkt_t got[$], input pkt_t exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check(name, got[i], exp[i]);
  endtask

  task automatic drain(input int want_a, input int want_b, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = (got_a.size() >= want_a) && (got_b.size() >= want_b);
    end
    check({name, "_drain_in_time"}, ok, 1);
  endtask

  initial begin
    bit   found;
    pkt_t hold;
    pkt_t exp_all[$];
    nreset = 1'b1; wait_in = 1'b0;
    #1 nreset = 1'b0;
    repeat (3) step();
    check("rst_access_out", access_out, 0);
    check("rst_a_wait", a_wait_out, 0);
    check("rst_b_wait", b_wait_out, 0);
    check("rst_packet_out", packet_out, 0);
    step();
    nreset = 1'b1;

    // Single beat on A: one cycle from accept edge to access_out
    clear_sb();
    push_a({8'hAA, 64'h0, 32'hDEAD_0001});
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = a_wait_out;
    end
    check("single_accepted", found, 1);
    check("single_not_yet", access_out, 0);
    step();
    check("single_access", access_out, 1);
    check("single_packet", packet_out, {8'hAA, 64'h0, 32'hDEAD_0001});
    check("single_wait_one_cycle", a_wait_out, 0);
    step();
    check("single_done", access_out, 0);

    // Backpressure: both ports fill while wait_in is held
    step();
    clear_sb();
    wait_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_a(mk(8'hAA, 8'hC0 + 8'(i)));
      push_b(mk(8'hBB, 8'hD0 + 8'(i)));
    end
    hold = '0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 4) hold = packet_out;
      if (i > 4) check("bp_stable", packet_out, hold);
    end
    check("bp_a_wait", a_wait_out, 1);
    check("bp_b_wait", b_wait_out, 1);
    check("bp_access", access_out, 1);
    wait_in = 1'b0;
    drain(3, 3, 60, "bp");
    repeat (3) step();
    cmp_q("bp_a", got_a, pushed_a);
    cmp_q("bp_b", got_b, pushed_b);

    // Output hold: wait_in toggles every cycle over a 20-beat A stream
    clear_sb();
    for (int i = 0; i < 20; i++) push_a(mk(8'hAA, 8'h20 + 8'(i)));
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      wait_in = ~wait_in;
      found = (got_a.size() >= 20);
    end
    wait_in = 1'b0;
    check("hold_drain_in_time", found, 1);
    repeat (3) step();
    cmp_q("hold_a", got_a, pushed_a);

    // Idle: outputs stay quiet and packet_out keeps its last value
    hold = packet_out;
    for (int i = 0; i < 50; i++) begin
      step();
      if (access_out || a_wait_out || b_wait_out || packet_out !== hold)
        check("idle_quiet", {access_out, a_wait_out, b_wait_out, packet_out}, {3'b000, hold});
    end
    check("idle_packet_held", packet_out, hold);
    check("idle_access", access_out, 0);

    // Reset mid-flight with both buffers and the output full
    clear_sb();
    wait_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      push_a(mk(8'hAA, 8'h50 + 8'(i)));
      push_b(mk(8'hBB, 8'h60 + 8'(i)));
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = a_wait_out && b_wait_out && access_out;
    end
    check("rstmid_filled", found, 1);
    flush = 1'b1;
    @(posedge clk);
    #3 nreset = 1'b0;
    #1;
    check("rstmid_access", access_out, 0);
    check("rstmid_a_wait", a_wait_out, 0);
    check("rstmid_b_wait", b_wait_out, 0);
    step();
    flush = 1'b0;
    wait_in = 1'b0;
    clear_sb();
    // Contention: offered during reset (must be ignored), accepted together on release
    for (int i = 0; i < 8; i++) begin
      push_a(mk(8'hAA, 8'hA0 + 8'(i)));
      push_b(mk(8'hBB, 8'hB0 + 8'(i)));
    end
    step();
    step();
    check("rstmid_ignored_access", access_out, 0);
    nreset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = (got_all.size() >= 16);
    end
    check("cont_in_time", found, 1);
    exp_all.delete();
    for (int i = 0; i < 8; i++) begin
      if (RR) begin
        exp_all.push_back(mk(8'hAA, 8'hA0 + 8'(i)));
        exp_all.push_back(mk(8'hBB, 8'hB0 + 8'(i)));
      end else begin
        exp_all.push_back(mk(8'hBB, 8'hB0 + 8'(i)));
        exp_all.push_back(mk(8'hAA, 8'hA0 + 8'(i)));
      end
    end
    cmp_q("cont_order", got_all, exp_all);
    if (got_cyc.size() >= 16) check("cont_one_per_cycle", got_cyc[15] - got_cyc[0], 15);

    // Randomized traffic with random gaps and random downstream wait
    clear_sb();
    gap_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      push_a({8'hAA, $urandom, $urandom, $urandom});
      push_b({8'hBB, $urandom, $urandom, $urandom});
    end
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step();
      wait_in = ($urandom_range(0, 3) == 0);
      found = (got_a.size() >= 60) && (got_b.size() >= 60);
    end
    wait_in = 1'b0;
    check("rand_in_time", found, 1);
    repeat (3) step();
    cmp_q("rand_a", got_a, pushed_a);
    cmp_q("rand_b", got_b, pushed_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
